// File: rtl/fetch_stage_if.sv
// Bundle of the decode-side handshake and instruction-BRAM read port of the fetch stage.
// The fetch stage connects through the master modport; the surrounding core/memory through slave.
`timescale 1ns/1ps
interface fetch_stage_if #(
    parameter int ADDR_W = 14
);
    logic              enable;
    logic [31:0]       pc_in;
    logic              flush;
    logic              done;
    logic [31:0]       pc;
    logic [31:0]       command;
    logic              misaligned;
    logic              busy;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       fetch_count;

    modport master (
        input  enable, pc_in, flush, imem_rdata,
        output done, pc, command, misaligned, busy, imem_en, imem_addr, fetch_count
    );

    modport slave (
        output enable, pc_in, flush, imem_rdata,
        input  done, pc, command, misaligned, busy, imem_en, imem_addr, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one BRAM word read per accepted enable, with a one-cycle done pulse
// toward decode, flush abort, and misaligned-PC detection without a memory access.
`timescale 1ns/1ps
module fetch_stage #(
    parameter int ADDR_W      = 14,
    parameter int MEM_LATENCY = 1
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       command_q, command_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic              misaligned_q, misaligned_d;
    logic              imem_en_q, imem_en_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pc_q          <= '0;
            command_q     <= '0;
            fetch_count_q <= '0;
            misaligned_q  <= 1'b0;
            imem_en_q     <= 1'b0;
            imem_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            command_q     <= command_d;
            fetch_count_q <= fetch_count_d;
            misaligned_q  <= misaligned_d;
            imem_en_q     <= imem_en_d;
            imem_addr_q   <= imem_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        command_d     = command_q;
        fetch_count_d = fetch_count_q;
        misaligned_d  = misaligned_q;
        imem_en_d     = 1'b0;
        imem_addr_d   = imem_addr_q;

        case (state_q)
            IDLE: begin
                // flush outranks enable, so a simultaneous start is dropped
                if (bus.enable && !bus.flush) begin
                    pc_d = bus.pc_in;
                    if (bus.pc_in[1:0] == 2'b00) begin
                        imem_addr_d = bus.pc_in[ADDR_W+1:2];
                        imem_en_d   = 1'b1;
                        cnt_d       = LAT;
                        state_d     = WAIT;
                    end else begin
                        command_d    = '0;
                        misaligned_d = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    command_d     = bus.imem_rdata;
                    misaligned_d  = 1'b0;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.done        = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.pc          = pc_q;
    assign bus.command     = command_q;
    assign bus.misaligned  = misaligned_q;
    assign bus.imem_en     = imem_en_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.fetch_count = fetch_count_q;

endmodule
